// File: rtl/instr_issue_sequencer_if.sv
// Issue handshake bundle between the sequencer (master) and the pipeline (slave).
interface instr_issue_sequencer_if;
   logic       issue_valid;
   logic [2:0] issue_sel;
   logic       issue_ready;

   modport master (output issue_valid, output issue_sel, input issue_ready);
   modport slave  (input issue_valid, input issue_sel, output issue_ready);
endinterface

// File: rtl/instr_issue_sequencer.sv
// Button-driven instruction issue sequencer: synchronise go, decode board selection, issue, drain.
// Optional go debounce is compiled in with `define ISSUE_SEQ_DEBOUNCE_EN.
//
// state   | meaning
// S_IDLE  | waiting for a go press
// S_ISSUE | selector presented, waiting for issue_ready
// S_DRAIN | counting PIPE_DEPTH drain cycles
// S_DONE  | one-cycle completion, bumps issue_count
// S_ERR   | last latched selection was invalid
module instr_issue_sequencer #(
   parameter int PIPE_DEPTH      = 5,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [3:0]               switches,
   input  logic [2:0]               buttons,
   input  logic                     go,
   instr_issue_sequencer_if.master  issue,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [7:0]               issue_count
);
   localparam int CNT_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(PIPE_DEPTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE, S_ERR} state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_go_meta;
   logic             r_go_sync;
   logic             r_go_prev;
   logic             w_go_lvl;
   logic             w_go_pulse;
   logic [2:0]       r_sel;
   logic [2:0]       w_dec_sel;
   logic             w_dec_valid;
   logic [CNT_W-1:0] r_drain_cnt;
   logic [7:0]       r_issue_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_go_meta <= 1'b0;
         r_go_sync <= 1'b0;
         r_go_prev <= 1'b0;
      end else begin
         r_go_meta <= go;
         r_go_sync <= r_go_meta;
         r_go_prev <= w_go_lvl;
      end
   end

`ifdef ISSUE_SEQ_DEBOUNCE_EN
   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   logic [DB_W-1:0] r_db_cnt;
   logic            r_go_db;

   // Level flips only after the synchronised input disagrees for DEBOUNCE_CYCLES in a row.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_db_cnt <= '0;
         r_go_db  <= 1'b0;
      end else if (r_go_sync == r_go_db) begin
         r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
         r_db_cnt <= '0;
         r_go_db  <= r_go_sync;
      end else begin
         r_db_cnt <= r_db_cnt + 1'b1;
      end
   end
   assign w_go_lvl = r_go_db;
`else
   // Parameter still referenced so both builds share one instance signature.
   assign w_go_lvl = r_go_sync & (DEBOUNCE_CYCLES >= 0);
`endif

   assign w_go_pulse = w_go_lvl & ~r_go_prev;

   always_comb begin
      w_dec_valid = 1'b1;
      w_dec_sel   = 3'd0;
      case (switches)
         4'b1000: w_dec_sel = 3'd0;
         4'b0100: w_dec_sel = 3'd1;
         4'b0010: w_dec_sel = 3'd2;
         4'b0001: begin
            case (buttons)
               3'b010:  w_dec_sel = 3'd3;
               3'b110:  w_dec_sel = 3'd4;
               3'b000:  w_dec_sel = 3'd5;
               3'b001:  w_dec_sel = 3'd6;
               3'b111:  w_dec_sel = 3'd7;
               default: w_dec_valid = 1'b0;
            endcase
         end
         default: w_dec_valid = 1'b0;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_ERR: begin
            if (w_go_pulse) w_next = w_dec_valid ? S_ISSUE : S_ERR;
         end
         S_ISSUE: if (issue.issue_ready) w_next = S_DRAIN;
         S_DRAIN: if (r_drain_cnt == '0) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_sel         <= 3'd0;
         r_drain_cnt   <= '0;
         r_issue_count <= 8'd0;
      end else begin
         r_state <= w_next;
         if ((r_state == S_IDLE || r_state == S_ERR) && w_go_pulse) r_sel <= w_dec_sel;
         if (r_state == S_ISSUE && issue.issue_ready) begin
            r_drain_cnt <= DRAIN_LOAD;
         end else if (r_state == S_DRAIN && r_drain_cnt != '0) begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
         end
         if (r_state == S_DONE) r_issue_count <= r_issue_count + 8'd1;
      end
   end

   assign issue.issue_valid = (r_state == S_ISSUE);
   assign issue.issue_sel   = (r_state == S_ISSUE) ? r_sel : 3'd0;
   assign busy              = (r_state == S_ISSUE) || (r_state == S_DRAIN) || (r_state == S_DONE);
   assign done              = (r_state == S_DONE);
   assign err               = (r_state == S_ERR);
   assign issue_count       = r_issue_count;
endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Self-checking bench for instr_issue_sequencer against a transaction-level model.
module tb_instr_issue_sequencer;
   localparam int PIPE_DEPTH = 5;
   localparam int DEBOUNCE   = 16;
   localparam int BUDGET     = 64;
`ifdef ISSUE_SEQ_DEBOUNCE_EN
   localparam int GO_HI = DEBOUNCE + 4;
   localparam int REL   = DEBOUNCE + 4;
`else
   localparam int GO_HI = 1;
   localparam int REL   = 1;
`endif
   localparam logic [2:0] BT_TAB [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] switches;
   logic [2:0] buttons;
   logic       go;
   logic       busy, done, err;
   logic [7:0] issue_count;

   int n_tests = 0;
   int n_fail  = 0;
   int m_count = 0;

   instr_issue_sequencer_if u_if();

   instr_issue_sequencer #(.PIPE_DEPTH(PIPE_DEPTH), .DEBOUNCE_CYCLES(DEBOUNCE)) dut (
      .clk(clk), .reset(reset), .switches(switches), .buttons(buttons), .go(go),
      .issue(u_if), .busy(busy), .done(done), .err(err), .issue_count(issue_count));

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit ref_decode(input logic [3:0] sw, input logic [2:0] bt, output logic [2:0] sel);
      sel = 3'd0;
      for (int k = 0; k < 3; k++) if (sw == (4'b1000 >> k)) begin sel = 3'(k); return 1'b1; end
      if (sw == 4'b0001)
         for (int k = 0; k < 5; k++) if (bt == BT_TAB[k]) begin sel = 3'(k + 3); return 1'b1; end
      return 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; go = 1'b0; u_if.issue_ready = 1'b0;
      switches = 4'd0; buttons = 3'd0;
      tick(); tick();
      reset = 1'b0; m_count = 0;
   endtask

   task automatic press_watch(output bit saw_v);
      saw_v = 0; go = 1'b1;
      for (int i = 0; i < GO_HI + REL + 2; i++) begin
         if (i == GO_HI) go = 1'b0;
         if (u_if.issue_valid === 1'b1) saw_v = 1;
         tick();
      end
   endtask

   // Press go, wait for the issue, hold ready low rdy_delay cycles, then measure drain and done.
   task automatic run_issue(input int rdy_delay, input bit toggle,
                            output int lat, output int hold, output logic [2:0] sel0,
                            output bit stable, output int drain, output int done_w,
                            output bit bad, output bit err_v, output bit tout);
      lat = 0; hold = 0; drain = 0; done_w = 0; stable = 1; bad = 0; tout = 0; sel0 = 3'd0; err_v = 0;
      u_if.issue_ready = 1'b0;
      go = 1'b1;
      while (u_if.issue_valid !== 1'b1 && lat < BUDGET) begin
         tick(); lat++;
         if (lat == GO_HI) go = 1'b0;
      end
      if (lat >= BUDGET) begin tout = 1; go = 1'b0; return; end
      sel0 = u_if.issue_sel; err_v = err;
      repeat (rdy_delay) begin
         if (u_if.issue_valid !== 1'b1 || u_if.issue_sel !== sel0) stable = 0;
         hold++;
         if (toggle) begin switches = 4'($urandom); buttons = 3'($urandom); end
         tick();
      end
      if (u_if.issue_valid !== 1'b1 || u_if.issue_sel !== sel0) stable = 0;
      u_if.issue_ready = 1'b1;
      tick();
      u_if.issue_ready = 1'b0;
      while (done !== 1'b1 && drain < BUDGET) begin
         if (u_if.issue_valid !== 1'b0 || busy !== 1'b1) bad = 1;
         if (toggle) u_if.issue_ready = 1'($urandom);
         drain++; tick();
      end
      u_if.issue_ready = 1'b0;
      if (drain >= BUDGET) tout = 1;
      while (done === 1'b1 && done_w < 4) begin
         if (busy !== 1'b1) bad = 1;
         done_w++; tick();
      end
      go = 1'b0;
      repeat (REL) tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({u_if.issue_valid, u_if.issue_sel, busy, done, err, issue_count} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b sel=%0d busy=%b done=%b err=%b cnt=%0d, want all 0",
                  u_if.issue_valid, u_if.issue_sel, busy, done, err, issue_count);
      end
   endtask

   task automatic test_basic();
      int lat, hold, drain, done_w; logic [2:0] sel; bit stable, bad, ev, tout;
      switches = 4'b1000; buttons = 3'b000;
      run_issue(0, 0, lat, hold, sel, stable, drain, done_w, bad, ev, tout);
      m_count = (m_count + 1) % 256;
      n_tests++; if (tout) begin n_fail++; $display("FAIL basic_timeout: issue or drain never finished"); end
`ifndef ISSUE_SEQ_DEBOUNCE_EN
      n_tests++; if (lat != 3) begin n_fail++; $display("FAIL basic_latency: got %0d want 3", lat); end
`endif
      n_tests++; if (sel !== 3'd0) begin n_fail++; $display("FAIL basic_sel: got %0d want 0", sel); end
      n_tests++; if (drain != PIPE_DEPTH) begin n_fail++; $display("FAIL basic_drain: got %0d want %0d", drain, PIPE_DEPTH); end
      n_tests++; if (done_w != 1) begin n_fail++; $display("FAIL basic_done_width: got %0d want 1", done_w); end
      n_tests++; if (bad) begin n_fail++; $display("FAIL basic_drain_outputs: valid high or busy low during drain/done"); end
      n_tests++; if (issue_count !== 8'(m_count)) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", issue_count, m_count); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_hold();
      int lat, hold, drain, done_w; logic [2:0] sel; bit stable, bad, ev, tout;
      switches = 4'b0001; buttons = 3'b111;
      run_issue(4, 1, lat, hold, sel, stable, drain, done_w, bad, ev, tout);
      m_count = (m_count + 1) % 256;
      n_tests++; if (tout || sel !== 3'd7) begin n_fail++; $display("FAIL hold_sel: got %0d want 7 (timeout=%0d)", sel, tout); end
      n_tests++; if (hold != 4 || !stable) begin n_fail++; $display("FAIL hold_stable: held %0d stable=%0d want 4 stable=1", hold, stable); end
      n_tests++; if (issue_count !== 8'(m_count)) begin n_fail++; $display("FAIL hold_count: got %0d want %0d", issue_count, m_count); end
   endtask

   task automatic test_err();
      int lat, hold, drain, done_w; logic [2:0] sel; bit stable, bad, ev, tout, saw_v;
      switches = 4'b0011; buttons = 3'b000;
      press_watch(saw_v);
      n_tests++; if (err !== 1'b1 || busy !== 1'b0 || saw_v) begin
         n_fail++; $display("FAIL err_enter: err=%b busy=%b saw_valid=%0d want 1 0 0", err, busy, saw_v);
      end
      u_if.issue_ready = 1'b1; tick(); tick(); u_if.issue_ready = 1'b0;
      n_tests++; if (err !== 1'b1 || u_if.issue_valid !== 1'b0 || u_if.issue_sel !== 3'd0) begin
         n_fail++; $display("FAIL err_ready_ignored: err=%b v=%b sel=%0d want 1 0 0", err, u_if.issue_valid, u_if.issue_sel);
      end
      switches = 4'b0001; buttons = 3'b110;
      run_issue(1, 0, lat, hold, sel, stable, drain, done_w, bad, ev, tout);
      m_count = (m_count + 1) % 256;
      n_tests++; if (tout || sel !== 3'd4 || ev) begin
         n_fail++; $display("FAIL err_recover: sel=%0d err_at_issue=%0d timeout=%0d want 4 0 0", sel, ev, tout);
      end
      n_tests++; if (err !== 1'b0 || issue_count !== 8'(m_count)) begin
         n_fail++; $display("FAIL err_after: err=%b cnt=%0d want 0 %0d", err, issue_count, m_count);
      end
   endtask

   task automatic test_go_in_drain();
      int lat, n_done, n_valid;
      switches = 4'b0100; u_if.issue_ready = 1'b0;
      lat = 0; go = 1'b1;
      while (u_if.issue_valid !== 1'b1 && lat < BUDGET) begin tick(); lat++; if (lat == 1) go = 1'b0; end
      u_if.issue_ready = 1'b1; tick(); u_if.issue_ready = 1'b0;
      go = 1'b1; tick(); go = 1'b0;
      n_done = 0; n_valid = 0;
      for (int i = 0; i < 30; i++) begin
         if (done === 1'b1) n_done++;
         if (u_if.issue_valid === 1'b1) n_valid++;
         tick();
      end
      m_count = (m_count + 1) % 256;
      n_tests++; if (lat >= BUDGET || n_done != 1 || n_valid != 0) begin
         n_fail++; $display("FAIL drain_go_ignored: dones=%0d valids=%0d want 1 0", n_done, n_valid);
      end
      n_tests++; if (issue_count !== 8'(m_count)) begin n_fail++; $display("FAIL drain_go_count: got %0d want %0d", issue_count, m_count); end
   endtask

   task automatic test_random();
      int lat, hold, drain, done_w, dly; logic [2:0] sel, es; bit stable, bad, ev, tout, saw_v, exp_err;
      exp_err = err;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 1) == 1) begin
            int k = $urandom_range(0, 7);
            if (k < 3) begin switches = 4'(4'b1000 >> k); buttons = 3'($urandom); end
            else begin switches = 4'b0001; buttons = BT_TAB[k - 3]; end
         end else begin
            switches = 4'($urandom); buttons = 3'($urandom);
         end
         u_if.issue_ready = 1'b1; tick(); tick(); u_if.issue_ready = 1'b0;
         n_tests++; if (busy !== 1'b0 || u_if.issue_valid !== 1'b0 || err !== exp_err) begin
            n_fail++; $display("FAIL rand_idle[%0d]: busy=%b v=%b err=%b want 0 0 %b", it, busy, u_if.issue_valid, err, exp_err);
         end
         if (ref_decode(switches, buttons, es)) begin
            dly = $urandom_range(0, 3);
            run_issue(dly, 1, lat, hold, sel, stable, drain, done_w, bad, ev, tout);
            m_count = (m_count + 1) % 256; exp_err = 0;
            n_tests++; if (tout || sel !== es || ev) begin
               n_fail++; $display("FAIL rand_sel[%0d]: got %0d err=%0d want %0d err=0", it, sel, ev, es);
            end
            n_tests++; if (hold != dly || !stable || bad || drain != PIPE_DEPTH || done_w != 1) begin
               n_fail++; $display("FAIL rand_seq[%0d]: hold=%0d stable=%0d bad=%0d drain=%0d done=%0d want %0d 1 0 %0d 1",
                                  it, hold, stable, bad, drain, done_w, dly, PIPE_DEPTH);
            end
            n_tests++; if (issue_count !== 8'(m_count)) begin
               n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", it, issue_count, m_count);
            end
         end else begin
            press_watch(saw_v); exp_err = 1;
            n_tests++; if (err !== 1'b1 || saw_v || busy !== 1'b0) begin
               n_fail++; $display("FAIL rand_err[%0d]: err=%b saw_valid=%0d busy=%b want 1 0 0", it, err, saw_v, busy);
            end
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      int lat, hold, drain, done_w; logic [2:0] sel; bit stable, bad, ev, tout;
      switches = 4'b0010; u_if.issue_ready = 1'b0;
      lat = 0; go = 1'b1;
      while (u_if.issue_valid !== 1'b1 && lat < BUDGET) begin tick(); lat++; if (lat == GO_HI) go = 1'b0; end
      go = 1'b0;
      u_if.issue_ready = 1'b1; tick(); u_if.issue_ready = 1'b0;
      tick(); tick();
      n_tests++; if (busy !== 1'b1 || issue_count == 8'd0) begin
         n_fail++; $display("FAIL rst_drain_setup: busy=%b cnt=%0d want 1 nonzero", busy, issue_count);
      end
      reset = 1'b1; tick();
      n_tests++; if ({u_if.issue_valid, u_if.issue_sel, busy, done, err, issue_count} !== 15'd0) begin
         n_fail++; $display("FAIL rst_drain_outputs: v=%b sel=%0d busy=%b done=%b err=%b cnt=%0d want all 0",
                            u_if.issue_valid, u_if.issue_sel, busy, done, err, issue_count);
      end
      reset = 1'b0; m_count = 0;
      repeat (REL) tick();
      switches = 4'b1000;
      run_issue(0, 0, lat, hold, sel, stable, drain, done_w, bad, ev, tout);
      m_count = 1;
      n_tests++; if (tout || issue_count !== 8'd1 || drain != PIPE_DEPTH) begin
         n_fail++; $display("FAIL rst_drain_resume: cnt=%0d drain=%0d want 1 %0d", issue_count, drain, PIPE_DEPTH);
      end
   endtask

   task automatic test_wrap();
      int lat, hold, drain, done_w; logic [2:0] sel; bit stable, bad, ev, tout;
      do_reset();
      switches = 4'b1000;
      for (int i = 0; i < 256; i++) begin
         run_issue(0, 0, lat, hold, sel, stable, drain, done_w, bad, ev, tout);
         m_count = (m_count + 1) % 256;
         if (i == 254) begin
            n_tests++; if (issue_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d want 255", issue_count); end
         end
      end
      n_tests++; if (issue_count !== 8'(m_count) || m_count != 0) begin
         n_fail++; $display("FAIL wrap_zero: got %0d want 0", issue_count);
      end
   endtask

`ifdef ISSUE_SEQ_DEBOUNCE_EN
   task automatic test_debounce();
      int n_v, n_d;
      do_reset();
      switches = 4'b1000; u_if.issue_ready = 1'b1;
      n_v = 0; go = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (i == 10) go = 1'b0;
         if (busy === 1'b1 || u_if.issue_valid === 1'b1) n_v++;
         tick();
      end
      n_tests++; if (n_v != 0) begin n_fail++; $display("FAIL db_glitch: busy cycles %0d want 0", n_v); end
      n_v = 0; n_d = 0; go = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (i == 20) go = 1'b0;
         if (u_if.issue_valid === 1'b1) n_v++;
         if (done === 1'b1) n_d++;
         tick();
      end
      u_if.issue_ready = 1'b0;
      n_tests++; if (n_v != 1 || n_d != 1 || issue_count !== 8'd1) begin
         n_fail++; $display("FAIL db_hold: valids=%0d dones=%0d cnt=%0d want 1 1 1", n_v, n_d, issue_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_err();
`ifndef ISSUE_SEQ_DEBOUNCE_EN
      test_go_in_drain();
`endif
      test_random();
      test_reset_mid_drain();
      test_wrap();
`ifdef ISSUE_SEQ_DEBOUNCE_EN
      test_debounce();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
